// File: rtl/td_meas_pkg.sv
// Shared parameters for the AGC timing-measurement path: field width, offsets,
// timeout default and the td_meas state encoding.
package td_meas_pkg;

    // Width of every time field and of the measurement cycle counter.
    localparam int unsigned TD_BIT_WIDTH = 22;

    // Fixed td offset applied by the downstream threshold comparison.
    localparam int unsigned TD_OFFSET = 2;

    // Counter value at which an unfinished window is abandoned; kept below all-ones
    // so a saturated field can never be confused with a real capture.
    localparam int unsigned TD_TIMEOUT = 32'h003F_FFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } td_state_e;

    typedef struct packed {
        logic ori_up;
        logic ori_dn;
        logic amp_up;
    } td_flags_t;

endpackage

// File: rtl/td_meas_edge_cap.sv
// Edge detector for one comparator input with an optional 2-flop synchronizer.
// Optional synchronizer enabled by defining TD_MEAS_SYNC_EN.
module edge_cap (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic in,
    output logic rise,
    output logic fall
);

    logic s;
    logic hist_q;

`ifdef TD_MEAS_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], in};
        end
    end

    assign s = sync_q[1];
`else
    assign s = in;
`endif

    // History tracks every cycle, so the value loaded on arm is the level seen at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= s;
        end
    end

    // The arm cycle belongs to no window; suppress edges there.
    assign rise = s & ~hist_q & ~arm;
    assign fall = ~s & hist_q & ~arm;

endmodule

// File: rtl/td_meas.sv
// Measures cycles to the original-path edge, its pulse width and the amplified-path
// edge after each start. Optional input synchronizers: define TD_MEAS_SYNC_EN.
module td_meas
    import td_meas_pkg::*;
#(
    parameter int unsigned bit_width = TD_BIT_WIDTH,
    parameter int unsigned TIMEOUT   = TD_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ori_hit,
    input  logic                 amp_hit,
    output logic [bit_width-1:0] t_ori_a,
    output logic [bit_width-1:0] t_ori_b,
    output logic [bit_width-1:0] t_amp,
    output logic                 valid,
    output logic                 timeout,
    output logic                 busy
);

    localparam logic [bit_width-1:0] TO_V = bit_width'(TIMEOUT);

    td_state_e            state_q;
    td_flags_t            flags_q, flags_d;
    logic [bit_width-1:0] cnt_q;
    logic [bit_width-1:0] ori_a_q, ori_a_d;
    logic [bit_width-1:0] ori_b_q, ori_b_d;
    logic [bit_width-1:0] amp_q, amp_d;
    logic [bit_width-1:0] t_ori_a_q, t_ori_b_q, t_amp_q;
    logic                 valid_q, timeout_q;

    logic arm;
    logic ori_rise, ori_fall;
    logic amp_rise, amp_fall;
    logic finish, expire;

    // An uncaptured field reports all-ones.
    function automatic logic [bit_width-1:0] field_or_ones(
        input logic                 got,
        input logic [bit_width-1:0] v
    );
        return got ? v : '1;
    endfunction

    assign arm = (state_q == ST_IDLE) && start;

    edge_cap u_ori (
        .clk  (clk),
        .rst  (rst),
        .arm  (arm),
        .in   (ori_hit),
        .rise (ori_rise),
        .fall (ori_fall)
    );

    edge_cap u_amp (
        .clk  (clk),
        .rst  (rst),
        .arm  (arm),
        .in   (amp_hit),
        .rise (amp_rise),
        .fall (amp_fall)
    );

    always_comb begin
        flags_d = flags_q;
        ori_a_d = ori_a_q;
        ori_b_d = ori_b_q;
        amp_d   = amp_q;

        if (ori_rise && !flags_q.ori_up) begin
            ori_a_d        = cnt_q;
            flags_d.ori_up = 1'b1;
        end
        // The rise was captured in an earlier cycle, so ori_a_q already holds it.
        if (ori_fall && flags_q.ori_up && !flags_q.ori_dn) begin
            ori_b_d        = cnt_q - ori_a_q;
            flags_d.ori_dn = 1'b1;
        end
        if (amp_rise && !flags_q.amp_up) begin
            amp_d          = cnt_q;
            flags_d.amp_up = 1'b1;
        end

        finish = flags_d.ori_dn && flags_d.amp_up;
        expire = (cnt_q == TO_V) && !finish;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flags_q   <= '0;
            cnt_q     <= '0;
            ori_a_q   <= '0;
            ori_b_q   <= '0;
            amp_q     <= '0;
            t_ori_a_q <= '0;
            t_ori_b_q <= '0;
            t_amp_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        flags_q <= '0;
                    end
                end
                ST_RUN: begin
                    cnt_q   <= cnt_q + 1'b1;
                    flags_q <= flags_d;
                    ori_a_q <= ori_a_d;
                    ori_b_q <= ori_b_d;
                    amp_q   <= amp_d;
                    if (finish || expire) begin
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b1;
                        timeout_q <= expire;
                        t_ori_a_q <= field_or_ones(flags_d.ori_up, ori_a_d);
                        t_ori_b_q <= field_or_ones(flags_d.ori_dn, ori_b_d);
                        t_amp_q   <= field_or_ones(flags_d.amp_up, amp_d);
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign t_ori_a = t_ori_a_q;
    assign t_ori_b = t_ori_b_q;
    assign t_amp   = t_amp_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_td_meas.sv
// Directed bench for td_meas at bit_width=8, TIMEOUT=200; expected times shift
// by 2 when TD_MEAS_SYNC_EN is defined.
module tb_td_meas;

    localparam int BW = 8;
    localparam int TO = 200;
`ifdef TD_MEAS_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ori_hit = 1'b0;
    logic          amp_hit = 1'b0;
    logic [BW-1:0] t_ori_a, t_ori_b, t_amp;
    logic          valid, timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;

    td_meas #(.bit_width(BW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ori_hit (ori_hit),
        .amp_hit (amp_hit),
        .t_ori_a (t_ori_a),
        .t_ori_b (t_ori_b),
        .t_amp   (t_amp),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one window: ori high over [r,f) (f<0: never falls), amp high from m,
    // optional extra start at cycle st2, and a start pulse during DONE.
    task automatic run_window(input string nm, input int r, input int f, input int m,
                              input bit pre, input int st2, input int exp_vc,
                              input int exp_a, input int exp_b, input int exp_m,
                              input bit exp_to);
        int vc;
        int nvalid;
        logic [BW-1:0] ga, gb, gm;
        logic gto;
        vc = -1;
        nvalid = 0;
        ga = '0; gb = '0; gm = '0; gto = 1'b0;
        ori_hit = pre;
        amp_hit = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_at_cnt0: got %0b want 1", nm, busy);
        end
        for (int c = 0; c < 260; c++) begin
            ori_hit = pre || (r >= 0 && c >= r && (f < 0 || c < f));
            amp_hit = (m >= 0 && c >= m);
            start   = (c == st2) || (vc >= 0 && c == vc + 1);
            tick();
            start = 1'b0;
            if (vc >= 0 && c == vc + 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s start_in_done: busy got %0b want 0", nm, busy);
                end
            end
            if (valid === 1'b1) begin
                nvalid++;
                if (vc < 0) begin
                    vc  = c;
                    ga  = t_ori_a;
                    gb  = t_ori_b;
                    gm  = t_amp;
                    gto = timeout;
                end
            end
            if (vc >= 0 && c >= vc + 3) break;
        end
        n_cmp++;
        if (vc != exp_vc) begin
            n_bad++;
            $display("FAIL %s valid_cycle: got %0d want %0d", nm, vc, exp_vc);
        end
        n_cmp++;
        if (ga !== BW'(exp_a)) begin
            n_bad++;
            $display("FAIL %s t_ori_a: got %0d want %0d", nm, ga, exp_a);
        end
        n_cmp++;
        if (gb !== BW'(exp_b)) begin
            n_bad++;
            $display("FAIL %s t_ori_b: got %0d want %0d", nm, gb, exp_b);
        end
        n_cmp++;
        if (gm !== BW'(exp_m)) begin
            n_bad++;
            $display("FAIL %s t_amp: got %0d want %0d", nm, gm, exp_m);
        end
        n_cmp++;
        if (gto !== exp_to) begin
            n_bad++;
            $display("FAIL %s timeout: got %0b want %0b", nm, gto, exp_to);
        end
        n_cmp++;
        if (nvalid != 1) begin
            n_bad++;
            $display("FAIL %s valid_pulses: got %0d want 1", nm, nvalid);
        end
        ori_hit = 1'b0;
        amp_hit = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (t_ori_a !== BW'(exp_a) || t_amp !== BW'(exp_m) || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s hold: got a=%0d m=%0d v=%0b want a=%0d m=%0d v=0",
                     nm, t_ori_a, t_amp, valid, exp_a, exp_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++;
        if ({t_ori_a, t_ori_b, t_amp} !== '0 || valid !== 1'b0 ||
            timeout !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got a=%0d b=%0d m=%0d v=%0b to=%0b busy=%0b want all 0",
                     t_ori_a, t_ori_b, t_amp, valid, timeout, busy);
        end
    endtask

    task automatic test_basic();
        run_window("basic", 10, 25, 30, 1'b0, -1, 30 + SL, 10 + SL, 15, 30 + SL, 1'b0);
    endtask

    task automatic test_amp_first();
        run_window("amp_first", 12, 20, 5, 1'b0, -1, 20 + SL, 12 + SL, 8, 5 + SL, 1'b0);
    endtask

    task automatic test_simultaneous();
        run_window("simult", 3, 40, 40, 1'b0, -1, 40 + SL, 3 + SL, 37, 40 + SL, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_window("restart_ignored", 10, 25, 30, 1'b0, 7, 30 + SL, 10 + SL, 15, 30 + SL, 1'b0);
    endtask

    task automatic test_coincide();
        run_window("coincide", 3, 50, TO - SL, 1'b0, -1, TO, 3 + SL, 47, TO, 1'b0);
    endtask

    task automatic test_partial_timeout();
        run_window("no_amp", 3, 50, -1, 1'b0, -1, TO, 3 + SL, 47, 255, 1'b1);
        run_window("no_fall", 60, -1, 70, 1'b0, -1, TO, 60 + SL, 255, 70 + SL, 1'b1);
    endtask

    task automatic test_timeout();
        run_window("level_at_start", -1, -1, -1, 1'b1, -1, TO, 255, 255, 255, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int nv;
        nv = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ori_hit = (c >= 2);
            start   = (c == 7);
            rst     = (c == 9);
            tick();
            start = 1'b0;
            rst   = 1'b0;
            if (c == 8) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL restart_busy: got %0b want 1", busy);
                end
            end
        end
        ori_hit = 1'b0;
        n_cmp++;
        if ({t_ori_a, t_ori_b, t_amp} !== '0 || valid !== 1'b0 ||
            timeout !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_run_reset: got a=%0d b=%0d m=%0d v=%0b to=%0b busy=%0b want all 0",
                     t_ori_a, t_ori_b, t_amp, valid, timeout, busy);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_bad++;
            $display("FAIL after_reset_quiet: got %0d active cycles want 0", nv);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_amp_first();
        test_simultaneous();
        test_back_to_back();
        test_coincide();
        test_partial_timeout();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/td_meas.md
Name: td_meas

Overview:
- Upstream timing-measurement stage of the AGC loop.
- After each `start`, counts clock cycles to the original-path comparator edge, the original-path pulse width, and the amplified-path comparator edge.
- Presents `t_ori_a`, `t_ori_b` and `t_amp` with a one-cycle `valid` strobe to the downstream threshold comparison that updates the gain select.
- Missing events are flagged by saturated values plus a `timeout` flag.

Parameters:
- `bit_width`, 22, width of all time fields and of the cycle counter; taken from the shared parameter include.
- `TIMEOUT`, 22'h3FFFFE, counter value at which an unfinished measurement is abandoned; must be less than 2^bit_width-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset.
- `start`  in  1  one-cycle request to begin a measurement window.
- `ori_hit`  in  1  original-path comparator output.
- `amp_hit`  in  1  amplified-path comparator output.
- `t_ori_a`  out  bit_width  cycles from window start to `ori_hit` rising edge.
- `t_ori_b`  out  bit_width  `ori_hit` high duration, in cycles.
- `t_amp`  out  bit_width  cycles from window start to `amp_hit` rising edge.
- `valid`  out  1  one-cycle strobe; all three times are new.
- `timeout`  out  1  qualifies `valid`: at least one event was missing.
- `busy`  out  1  high in RUN.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state IDLE; all outputs 0; counter 0; event flags cleared.
- State machine, IDLE -> RUN -> DONE -> IDLE.
  - IDLE: `start`=1 -> RUN. Counter cleared to 0. Edge-history registers loaded with the current `ori_hit` and `amp_hit`, so a level already high at `start` is not an edge. All event flags cleared.
  - RUN: counter equals 0 in the first RUN cycle and increments by 1 each cycle.
    - `ori_hit` rising edge (current 1, previous 0), first only: capture counter into the `ori_a` register; set `ori_up`.
    - `ori_hit` falling edge while `ori_up` and not `ori_dn`: capture (counter - `ori_a`) into `ori_b`; set `ori_dn`.
    - `amp_hit` rising edge, first only: capture counter into the `amp` register; set `amp_up`.
    - Later edges in the same window are ignored.
    - All captures in a cycle use the same counter value. Simultaneous events are all captured in that cycle.
  - RUN -> DONE on the clock edge where `ori_dn` and `amp_up` both become true, counting captures made in that same cycle.
  - RUN -> DONE also when the counter equals `TIMEOUT`. Every uncaptured field is forced to all-ones and `timeout` is set. If the final event and `TIMEOUT` coincide, the event is captured and `timeout`=0.
  - DONE lasts exactly one cycle. `t_*` and `timeout` outputs are updated on entry to DONE. `valid`=1 only in DONE. DONE -> IDLE unconditionally.
- Latency: `valid` is high in the cycle after the cycle containing the last required edge.
- `t_*` and `timeout` hold their values until the next DONE.
- `start` is ignored in RUN and DONE; there is no queuing.
- `busy` = (state == RUN).
- Arithmetic: unsigned, `bit_width` bits.
- The counter cannot wrap: `TIMEOUT` ends the window first.
- `t_ori_b` is never negative, since the fall is always later than the rise.
- `rst` during RUN: immediate return to IDLE, outputs cleared, no `valid`.

Optional Feature:
- Macro: `TD_MEAS_SYNC_EN`.
- Defined: `ori_hit` and `amp_hit` each pass through a 2-flop synchronizer before edge detection.
  - `t_ori_a` and `t_amp` read 2 higher than for the same pin timing; `t_ori_b` is unchanged.
  - The `valid` latency from a pin edge grows by 2 cycles.
  - The edge-history load at `start` uses the synchronized values.
- Not defined: inputs are sampled directly; the caller guarantees they are synchronous to `clk`.

Decomposition:
- `bit_width` stays in the shared parameter include, next to the existing `td` offset constant. `TIMEOUT` default and the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) are added there.
- One sub-module: `edge_cap`, instantiated twice (ori and amp).
  - Inputs: `clk`, `rst`, `arm`, `in`.
  - Outputs: `rise`, `fall`.
  - Contains the optional synchronizer and the history register.

Test Plan (bit_width=8, TIMEOUT=200, feature off unless noted):
- `start`; `ori_hit` rises at cnt 10, falls at 25; `amp_hit` rises at 30 -> `valid` one cycle after cnt 30; `t_ori_a`=10, `t_ori_b`=15, `t_amp`=30, `timeout`=0.
- `amp_hit` rises at 5; `ori_hit` high 12..20 -> `t_amp`=5, `t_ori_a`=12, `t_ori_b`=8; `valid` one cycle after cnt 20.
- `ori_hit` falls and `amp_hit` rises in the same cycle at cnt 40 (ori rose at 3) -> both captured; `t_ori_b`=37, `t_amp`=40; a single `valid`.
- `ori_hit` already high at `start`, no `amp_hit` -> `valid` after cnt 200; `timeout`=1; `t_ori_a`=`t_ori_b`=`t_amp`=255.
- `start` pulsed again at cnt 7, then `rst` at cnt 9 -> second `start` has no effect; after reset, `busy`=0, outputs 0, no `valid`.
- Scenario 1 with `TD_MEAS_SYNC_EN` -> `t_ori_a`=12, `t_ori_b`=15, `t_amp`=32.
